gray_scale_frame_controller: RTL and testbench

Frame-level sequencer for the RGB-to-grayscale datapath. It latches and validates the three fixed-point channel scales and issues one source-BRAM read per cycle across the whole frame. Write strobes and addresses for the destination BRAM are aligned to the datapath latency. The block sits between the system control (start/abort/stall) and the converter plus its read/write BRAMs, and reports busy/done/error status.

---
 rtl/gray_scale_frame_controller.sv | 176 +++++++++++++++++
 tb/tb_gray_scale_frame_controller.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/gray_scale_frame_controller.sv
// Frame sequencer for the RGB-to-grayscale datapath: validates and latches scales, walks the frame.
// Latency: first read one cycle after an accepted start; write strobes trail reads by PIPE_LATENCY.
// Backpressure: stall gates the read strobe in the same cycle; abort stops reads and drains in-flight pixels.
module gray_scale_frame_controller #(
  parameter int IMAGE_HEIGHT         = 270,
  parameter int IMAGE_WIDTH          = 480,
  parameter int TOTAL_NUMBER_CONVERT = IMAGE_HEIGHT * IMAGE_WIDTH,
  parameter int ADRR_WIDTH_BRAM      = 19,
  parameter int FIXED_POINT_WIDTH    = 32,
  parameter int POINT_POSITION       = FIXED_POINT_WIDTH / 2,
  parameter int PIPE_LATENCY         = 3,
  localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1,
  localparam int COL_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         start_i,
  input  logic                         abort_i,
  input  logic                         stall_i,
  input  logic [FIXED_POINT_WIDTH-1:0] cfg_scale_red_i,
  input  logic [FIXED_POINT_WIDTH-1:0] cfg_scale_green_i,
  input  logic [FIXED_POINT_WIDTH-1:0] cfg_scale_blue_i,
  output logic [FIXED_POINT_WIDTH-1:0] scale_red_o,
  output logic [FIXED_POINT_WIDTH-1:0] scale_green_o,
  output logic [FIXED_POINT_WIDTH-1:0] scale_blue_o,
  output logic                         conv_en_o,
  output logic                         rd_en_o,
  output logic [ADRR_WIDTH_BRAM-1:0]   rd_addr_o,
  output logic                         wr_en_o,
  output logic [ADRR_WIDTH_BRAM-1:0]   wr_addr_o,
  output logic [ROW_W-1:0]             row_o,
  output logic [COL_W-1:0]             col_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         aborted_o,
  output logic                         cfg_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  // 1.0 in the scale fixed-point format; the three scales may sum to at most this
  localparam logic [FIXED_POINT_WIDTH+1:0] SCALE_ONE =
    {{(FIXED_POINT_WIDTH+1){1'b0}}, 1'b1} << POINT_POSITION;
  localparam logic [ADRR_WIDTH_BRAM-1:0] LAST_ADDR = ADRR_WIDTH_BRAM'(TOTAL_NUMBER_CONVERT - 1);
  localparam logic [COL_W-1:0]           COL_LAST  = COL_W'(IMAGE_WIDTH - 1);
  // every delay-line stage except the one currently driving wr_en
  localparam logic [PIPE_LATENCY-1:0]    PIPE_HEAD_MASK = {PIPE_LATENCY{1'b1}} >> 1;

  state_t                         state_q;
  logic [FIXED_POINT_WIDTH-1:0]   scale_red_q, scale_green_q, scale_blue_q;
  logic [ADRR_WIDTH_BRAM-1:0]     rd_addr_q, wr_addr_q;
  logic [ROW_W-1:0]               row_q;
  logic [COL_W-1:0]               col_q;
  logic                           conv_en_q, busy_q, done_q, aborted_q, cfg_err_q, abort_q;
  logic [PIPE_LATENCY-1:0]        pipe_q, pipe_d;
  logic [FIXED_POINT_WIDTH+1:0]   scale_sum;
  logic                           scale_ok;
  logic                           last_rd;
  logic                           pipe_drained;

  assign scale_sum    = {2'b00, cfg_scale_red_i} + {2'b00, cfg_scale_green_i} + {2'b00, cfg_scale_blue_i};
  assign scale_ok     = (scale_sum <= SCALE_ONE);
  assign last_rd      = (rd_addr_q == LAST_ADDR);
  // once no stage behind the output holds a read, the current wr_en is the final one
  assign pipe_drained = ((pipe_q & PIPE_HEAD_MASK) == '0);

  // Read strobe reacts to stall/abort in the same cycle so a stalled cycle issues no read
  assign rd_en_o = (state_q == S_RUN) && !stall_i && !abort_i;
  assign wr_en_o = pipe_q[PIPE_LATENCY-1];

  // Delay-line next state: shift in this cycle's read strobe
  always_comb begin
    pipe_d    = pipe_q << 1;
    pipe_d[0] = rd_en_o;
  end

  // Delay line runs every cycle, independent of stall
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) pipe_q <= '0;
    else            pipe_q <= pipe_d;
  end

  // Frame FSM with registered status, scale latches and read/write address counters
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= S_IDLE;
      scale_red_q   <= '0;
      scale_green_q <= '0;
      scale_blue_q  <= '0;
      rd_addr_q     <= '0;
      wr_addr_q     <= '0;
      row_q         <= '0;
      col_q         <= '0;
      conv_en_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      cfg_err_q     <= 1'b0;
      abort_q       <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      cfg_err_q <= 1'b0;
      if (wr_en_o) wr_addr_q <= wr_addr_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (scale_ok) begin
              scale_red_q   <= cfg_scale_red_i;
              scale_green_q <= cfg_scale_green_i;
              scale_blue_q  <= cfg_scale_blue_i;
              rd_addr_q     <= '0;
              wr_addr_q     <= '0;
              row_q         <= '0;
              col_q         <= '0;
              abort_q       <= 1'b0;
              conv_en_q     <= 1'b1;
              busy_q        <= 1'b1;
              state_q       <= S_RUN;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (abort_i) begin
            abort_q <= 1'b1;
            state_q <= S_DRAIN;
          end else if (!stall_i) begin
            if (last_rd) begin
              state_q <= S_DRAIN;
            end else begin
              rd_addr_q <= rd_addr_q + 1'b1;
              if (col_q == COL_LAST) begin
                col_q <= '0;
                row_q <= row_q + 1'b1;
              end else begin
                col_q <= col_q + 1'b1;
              end
            end
          end
        end
        S_DRAIN: begin
          if (abort_i) abort_q <= 1'b1;
          if (pipe_drained) begin
            conv_en_q <= 1'b0;
            busy_q    <= 1'b0;
            if (abort_q || abort_i) begin
              aborted_q <= 1'b1;
              state_q   <= S_IDLE;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign scale_red_o   = scale_red_q;
  assign scale_green_o = scale_green_q;
  assign scale_blue_o  = scale_blue_q;
  assign conv_en_o     = conv_en_q;
  assign rd_addr_o     = rd_addr_q;
  assign wr_addr_o     = wr_addr_q;
  assign row_o         = row_q;
  assign col_o         = col_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign aborted_o     = aborted_q;
  assign cfg_err_o     = cfg_err_q;

endmodule

// File: tb/tb_gray_scale_frame_controller.sv
// Bench for gray_scale_frame_controller on a 4x5 frame with a 3-cycle datapath.
// Expected behaviour comes from a cycle-indexed event model (read times, write times, completion time).
module tb_gray_scale_frame_controller;

  localparam int H    = 4;
  localparam int W    = 5;
  localparam int N    = H * W;
  localparam int L    = 3;
  localparam int FPW  = 32;
  localparam int AW   = 19;
  localparam int MAXC = 200;

  logic           clk_i = 1'b0;
  logic           reset_n_i = 1'b0;
  logic           start_i = 1'b0, abort_i = 1'b0, stall_i = 1'b0;
  logic [FPW-1:0] cfg_r = '0, cfg_g = '0, cfg_b = '0;
  logic [FPW-1:0] scale_red_o, scale_green_o, scale_blue_o;
  logic           conv_en_o, rd_en_o, wr_en_o, busy_o, done_o, aborted_o, cfg_err_o;
  logic [AW-1:0]  rd_addr_o, wr_addr_o;
  logic [1:0]     row_o;
  logic [2:0]     col_o;

  int checks = 0;
  int errors = 0;
  logic [FPW-1:0] m_r = '0, m_g = '0, m_b = '0;  // scales the model believes are latched

  gray_scale_frame_controller #(
    .IMAGE_HEIGHT(H), .IMAGE_WIDTH(W), .ADRR_WIDTH_BRAM(AW),
    .FIXED_POINT_WIDTH(FPW), .POINT_POSITION(16), .PIPE_LATENCY(L)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i), .abort_i(abort_i), .stall_i(stall_i),
    .cfg_scale_red_i(cfg_r), .cfg_scale_green_i(cfg_g), .cfg_scale_blue_i(cfg_b),
    .scale_red_o(scale_red_o), .scale_green_o(scale_green_o), .scale_blue_o(scale_blue_o),
    .conv_en_o(conv_en_o), .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .row_o(row_o), .col_o(col_o),
    .busy_o(busy_o), .done_o(done_o), .aborted_o(aborted_o), .cfg_err_o(cfg_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input int cyc, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".rd_en"},   0, 64'(rd_en_o),   64'd0);
    chk({tag, ".rd_addr"}, 0, 64'(rd_addr_o), 64'd0);
    chk({tag, ".wr_en"},   0, 64'(wr_en_o),   64'd0);
    chk({tag, ".wr_addr"}, 0, 64'(wr_addr_o), 64'd0);
    chk({tag, ".row"},     0, 64'(row_o),     64'd0);
    chk({tag, ".col"},     0, 64'(col_o),     64'd0);
    chk({tag, ".busy"},    0, 64'(busy_o),    64'd0);
    chk({tag, ".conv_en"}, 0, 64'(conv_en_o), 64'd0);
    chk({tag, ".done"},    0, 64'(done_o),    64'd0);
    chk({tag, ".aborted"}, 0, 64'(aborted_o), 64'd0);
    chk({tag, ".cfg_err"}, 0, 64'(cfg_err_o), 64'd0);
    chk({tag, ".scale_r"}, 0, 64'(scale_red_o),   64'd0);
    chk({tag, ".scale_g"}, 0, 64'(scale_green_o), 64'd0);
    chk({tag, ".scale_b"}, 0, 64'(scale_blue_o),  64'd0);
  endtask

  // Runs one accepted frame starting just after a rising edge. Cycle k is the cycle after edge k,
  // with the start sampled at edge 0. Returns observed completion cycle, write count, last read cycle.
  task automatic run_frame(input logic [FPW-1:0] r, input logic [FPW-1:0] g, input logic [FPW-1:0] b,
                           input int stall_pct, input int s0, input int s1, input int abort_cyc,
                           input bit abort0, input int ign_start, input int rst_cyc,
                           output int pulse_c, output int n_wr, output int last_rd_c);
    bit rd_hist [0:MAXC];
    int next_pix, drain_start, pulse_exp, last_rd, writes, last_wr;
    bit running, was_abort, finished, exp_rd, exp_wr;
    for (int i = 0; i <= MAXC; i++) rd_hist[i] = 1'b0;
    next_pix = 0; drain_start = -1; pulse_exp = -1; last_rd = -1; writes = 0;
    running = 1'b1; was_abort = 1'b0; finished = 1'b0;
    pulse_c = -1; n_wr = 0; last_rd_c = -1;
    cfg_r = r; cfg_g = g; cfg_b = b;
    start_i = 1'b1; abort_i = abort0; stall_i = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b0; abort_i = 1'b0;
    m_r = r; m_g = g; m_b = b;
    for (int c = 1; c < MAXC; c++) begin
      stall_i = (c == s0) || (c == s1) || (int'($urandom_range(99)) < stall_pct);
      abort_i = running && (c == abort_cyc);
      start_i = (c == ign_start);
      if (c == rst_cyc) begin
        reset_n_i = 1'b0;
        #1;
        check_zero("mid_reset");
        stall_i = 1'b0; abort_i = 1'b0; start_i = 1'b0;
        finished = 1'b1;
        break;
      end
      exp_rd = running && !stall_i && !abort_i;
      exp_wr = (c > L) && rd_hist[c-L];
      @(negedge clk_i);
      if (wr_en_o) n_wr++;
      if (rd_en_o) last_rd_c = c;
      if ((done_o || aborted_o) && pulse_c < 0) pulse_c = c;
      chk("rd_en", c, 64'(rd_en_o), 64'(exp_rd));
      if (running) begin
        chk("rd_addr", c, 64'(rd_addr_o), 64'(next_pix));
        chk("row",     c, 64'(row_o),     64'(next_pix / W));
        chk("col",     c, 64'(col_o),     64'(next_pix % W));
      end
      chk("wr_en",   c, 64'(wr_en_o),   64'(exp_wr));
      chk("wr_addr", c, 64'(wr_addr_o), 64'(writes));
      chk("busy",    c, 64'(busy_o),    64'(pulse_exp < 0 || c < pulse_exp));
      chk("conv_en", c, 64'(conv_en_o), 64'(pulse_exp < 0 || c < pulse_exp));
      chk("done",    c, 64'(done_o),    64'(c == pulse_exp && !was_abort));
      chk("aborted", c, 64'(aborted_o), 64'(c == pulse_exp && was_abort));
      chk("cfg_err", c, 64'(cfg_err_o), 64'd0);
      chk("scale_r", c, 64'(scale_red_o),   64'(m_r));
      chk("scale_g", c, 64'(scale_green_o), 64'(m_g));
      chk("scale_b", c, 64'(scale_blue_o),  64'(m_b));
      if (exp_wr) writes++;
      if (running) begin
        if (abort_i) begin
          running = 1'b0; was_abort = 1'b1; drain_start = c + 1;
        end else if (!stall_i) begin
          rd_hist[c] = 1'b1; last_rd = c; next_pix++;
          if (next_pix == N) begin running = 1'b0; drain_start = c + 1; end
        end
        if (!running) begin
          last_wr   = (last_rd >= 0) ? last_rd + L : 0;
          pulse_exp = ((drain_start > last_wr) ? drain_start : last_wr) + 1;
        end
      end
      @(posedge clk_i); #1;
      if (c == pulse_exp) begin finished = 1'b1; break; end
    end
    stall_i = 1'b0; abort_i = 1'b0; start_i = 1'b0;
    chk("frame_end", 0, 64'(finished), 64'd1);
  endtask

  // Start with an over-unity scale sum; must pulse cfg_err and leave everything else idle.
  task automatic cfg_reject(input logic [FPW-1:0] r, input logic [FPW-1:0] g, input logic [FPW-1:0] b);
    cfg_r = r; cfg_g = g; cfg_b = b;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(negedge clk_i);
    chk("rej.cfg_err", 1, 64'(cfg_err_o), 64'd1);
    chk("rej.busy",    1, 64'(busy_o),    64'd0);
    chk("rej.conv_en", 1, 64'(conv_en_o), 64'd0);
    chk("rej.rd_en",   1, 64'(rd_en_o),   64'd0);
    chk("rej.scale_r", 1, 64'(scale_red_o),   64'(m_r));
    chk("rej.scale_g", 1, 64'(scale_green_o), 64'(m_g));
    chk("rej.scale_b", 1, 64'(scale_blue_o),  64'(m_b));
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("rej.cfg_err_pulse", 2, 64'(cfg_err_o), 64'd0);
    chk("rej.busy2",         2, 64'(busy_o),    64'd0);
    @(posedge clk_i); #1;
  endtask

  initial begin
    int pc, nw, lr;
    logic [FPW-1:0] rr, rg, rb;

    // reset state
    repeat (2) @(posedge clk_i);
    #1;
    check_zero("reset");
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    check_zero("idle_after_reset");

    // normal frame
    run_frame(32'd16384, 32'd16384, 32'd16384, 0, -1, -1, -1, 1'b0, -1, -1, pc, nw, lr);
    chk("normal.done_cycle", 0, 64'(pc), 64'd24);
    chk("normal.writes",     0, 64'(nw), 64'd20);
    chk("normal.last_read",  0, 64'(lr), 64'd20);

    // stall in cycles 3 and 4, started in the first IDLE cycle after DONE
    run_frame(32'd16384, 32'd16384, 32'd16384, 0, 3, 4, -1, 1'b0, -1, -1, pc, nw, lr);
    chk("stall.done_cycle", 0, 64'(pc), 64'd26);
    chk("stall.writes",     0, 64'(nw), 64'd20);
    chk("stall.last_read",  0, 64'(lr), 64'd22);

    // rejected configurations leave the previous scales in place
    cfg_reject(32'd32768, 32'd32768, 32'd16384);
    cfg_reject(32'd32768, 32'd16384, 32'd16385);

    // sum exactly 1.0 is accepted; random stalls
    run_frame(32'd32768, 32'd16384, 32'd16384, 25, -1, -1, -1, 1'b0, -1, -1, pc, nw, lr);
    chk("unity.writes", 0, 64'(nw), 64'd20);

    // abort in cycle 8 together with stall
    run_frame(32'd16384, 32'd16384, 32'd16384, 0, 8, -1, 8, 1'b0, -1, -1, pc, nw, lr);
    chk("abort.pulse_cycle", 0, 64'(pc), 64'd11);
    chk("abort.writes",      0, 64'(nw), 64'd7);
    chk("abort.last_read",   0, 64'(lr), 64'd7);
    @(negedge clk_i);
    chk("abort.idle_done", 0, 64'(done_o), 64'd0);
    @(posedge clk_i); #1;

    // start and abort together in IDLE: frame still runs to completion
    run_frame(32'd10000, 32'd20000, 32'd30000, 20, -1, -1, -1, 1'b1, -1, -1, pc, nw, lr);
    chk("start_abort.writes", 0, 64'(nw), 64'd20);

    // random scales, random stalls, random abort point
    for (int k = 0; k < 4; k++) begin
      rr = FPW'($urandom_range(0, 32768));
      rg = FPW'($urandom_range(0, 65536 - int'(rr)));
      rb = FPW'($urandom_range(0, 65536 - int'(rr) - int'(rg)));
      run_frame(rr, rg, rb, 30, -1, -1, (k[0] ? int'($urandom_range(2, 15)) : -1),
                1'b0, -1, -1, pc, nw, lr);
    end

    // start ignored while busy, then asynchronous reset mid-frame
    run_frame(32'd16384, 32'd16384, 32'd16384, 0, -1, -1, -1, 1'b0, 5, 10, pc, nw, lr);
    @(posedge clk_i); #1;
    check_zero("held_reset");
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    m_r = '0; m_g = '0; m_b = '0;
    run_frame(32'd16384, 32'd16384, 32'd16384, 0, -1, -1, -1, 1'b0, -1, -1, pc, nw, lr);
    chk("post_reset.done_cycle", 0, 64'(pc), 64'd24);
    chk("post_reset.writes",     0, 64'(nw), 64'd20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
